// File: rtl/biquad_scheduler.sv
// Shared-MAC biquad over NUM_CH channels: 7 cycles per channel, one y_valid per channel, frame = 7*NUM_CH cycles.
// No output backpressure; start/clear are ignored and coefficient writes dropped (coef_err) while busy.
module biquad_scheduler #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   start,
   input  logic                   clear,
   output logic [CH_W-1:0]        x_rd_ch,
   input  logic signed [15:0]     x_rd_data,
   input  logic                   coef_we,
   input  logic [CH_W-1:0]        coef_ch,
   input  logic [2:0]             coef_sel,
   input  logic signed [15:0]     coef_data,
   output logic                   coef_err,
   output logic                   y_valid,
   output logic [CH_W-1:0]        y_ch,
   output logic signed [15:0]     y_data,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {IDLE, MAC, SCALE, WB} state_t;

   state_t                state;
   logic [CH_W-1:0]       ch;
   logic [2:0]            k;
   logic signed [15:0]    acc;
   logic signed [15:0]    xcap;
   logic signed [15:0]    yreg;

   // coefficient slots: 0=b0 1=b1 2=b2 3=a0 4=a1 5=a2
   logic signed [15:0]    coef [NUM_CH][6];
   logic signed [15:0]    x1 [NUM_CH];
   logic signed [15:0]    x2 [NUM_CH];
   logic signed [15:0]    y1 [NUM_CH];
   logic signed [15:0]    y2 [NUM_CH];

   logic signed [15:0]    mul_a;
   logic signed [15:0]    mul_b;
   logic signed [31:0]    prod;
   logic signed [15:0]    prod_hi;

   assign x_rd_ch = ch;

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      if (state == SCALE) begin
         mul_a = coef[ch][3];
         mul_b = acc;
      end else begin
         case (k)
            3'd0: begin mul_a = coef[ch][0]; mul_b = x_rd_data; end
            3'd1: begin mul_a = coef[ch][1]; mul_b = x1[ch];    end
            3'd2: begin mul_a = coef[ch][2]; mul_b = x2[ch];    end
            3'd3: begin mul_a = coef[ch][4]; mul_b = y1[ch];    end
            default: begin mul_a = coef[ch][5]; mul_b = y2[ch]; end
         endcase
      end
   end

   assign prod    = mul_a * mul_b;
   assign prod_hi = 16'(prod >>> 16);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         ch       <= '0;
         k        <= '0;
         acc      <= '0;
         xcap     <= '0;
         yreg     <= '0;
         coef_err <= 1'b0;
         y_valid  <= 1'b0;
         y_ch     <= '0;
         y_data   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
            for (int j = 0; j < 6; j++) coef[i][j] <= '0;
         end
      end else begin
         y_valid  <= 1'b0;
         done     <= 1'b0;
         coef_err <= 1'b0;

         if (coef_we) begin
            if (state != IDLE)
               coef_err <= 1'b1;
            else if (32'(coef_ch) < NUM_CH && coef_sel <= 3'd5)
               coef[coef_ch][coef_sel] <= coef_data;
         end

         case (state)
            IDLE: begin
               // clear lands on the same edge that launches the frame, so a joint start+clear runs on zeroed history
               if (clear) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     x1[i] <= '0;
                     x2[i] <= '0;
                     y1[i] <= '0;
                     y2[i] <= '0;
                  end
               end
               if (start) begin
                  state <= MAC;
                  ch    <= '0;
                  k     <= '0;
                  busy  <= 1'b1;
               end
            end
            MAC: begin
               if (k == 3'd0) begin
                  xcap <= x_rd_data;
                  acc  <= prod_hi;
               end else begin
                  acc  <= acc + prod_hi;
               end
               if (k == 3'd4) begin
                  k     <= '0;
                  state <= SCALE;
               end else begin
                  k <= k + 3'd1;
               end
            end
            SCALE: begin
               yreg  <= prod_hi;
               state <= WB;
            end
            WB: begin
               x2[ch]  <= x1[ch];
               x1[ch]  <= xcap;
               y2[ch]  <= y1[ch];
               y1[ch]  <= yreg;
               y_valid <= 1'b1;
               y_ch    <= ch;
               y_data  <= yreg;
               if (32'(ch) == NUM_CH - 1) begin
                  state <= IDLE;
                  ch    <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= MAC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_biquad_scheduler.sv
// Scoreboard bench: a reference model predicts every channel output at frame start; a negedge monitor checks them.
module tb_biquad_scheduler;
   localparam int N = 4;

   logic               Clk = 1'b0;
   logic               Reset = 1'b0;
   logic               start = 1'b0;
   logic               clear = 1'b0;
   logic [1:0]         x_rd_ch;
   logic signed [15:0] x_rd_data;
   logic               coef_we = 1'b0;
   logic [1:0]         coef_ch = '0;
   logic [2:0]         coef_sel = '0;
   logic signed [15:0] coef_data = '0;
   logic               coef_err;
   logic               y_valid;
   logic [1:0]         y_ch;
   logic signed [15:0] y_data;
   logic               busy;
   logic               done;

   always #5 Clk = ~Clk;

   biquad_scheduler #(.NUM_CH(N), .CH_W(2)) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .clear(clear),
      .x_rd_ch(x_rd_ch), .x_rd_data(x_rd_data),
      .coef_we(coef_we), .coef_ch(coef_ch), .coef_sel(coef_sel), .coef_data(coef_data),
      .coef_err(coef_err), .y_valid(y_valid), .y_ch(y_ch), .y_data(y_data),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] y;
      logic        dn;
      int          at;
   } exp_t;

   exp_t               expq[$];
   exp_t               mon_e;
   int                 checks = 0;
   int                 failures = 0;
   int                 cyc = 0;
   int                 e0 = 0;
   int                 yv_seen = 0;
   int                 pushed = 0;
   logic [15:0]        last_y [N];
   logic signed [15:0] xin [N];
   logic signed [15:0] m_coef [N][6];
   logic signed [15:0] m_x1 [N];
   logic signed [15:0] m_x2 [N];
   logic signed [15:0] m_y1 [N];
   logic signed [15:0] m_y2 [N];

   assign x_rd_data = xin[x_rd_ch];

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Upper half of the exact signed product.
   function automatic logic signed [15:0] mh(input logic signed [15:0] a, input logic signed [15:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      return 16'(p >>> 16);
   endfunction

   task automatic model_hist_zero();
      for (int c = 0; c < N; c++) begin
         m_x1[c] = '0; m_x2[c] = '0; m_y1[c] = '0; m_y2[c] = '0;
      end
   endtask

   task automatic model_reset();
      model_hist_zero();
      for (int c = 0; c < N; c++)
         for (int s = 0; s < 6; s++) m_coef[c][s] = '0;
   endtask

   task automatic model_frame(input int at0);
      for (int c = 0; c < N; c++) begin
         int s;
         logic signed [15:0] acc;
         logic signed [15:0] y;
         exp_t e;
         s = int'(mh(m_coef[c][0], xin[c])) + int'(mh(m_coef[c][1], m_x1[c]))
           + int'(mh(m_coef[c][2], m_x2[c])) + int'(mh(m_coef[c][4], m_y1[c]))
           + int'(mh(m_coef[c][5], m_y2[c]));
         acc = 16'(s);
         y = mh(m_coef[c][3], acc);
         e.ch = 2'(c);
         e.y  = y;
         e.dn = (c == N - 1);
         e.at = at0 + 7 * (c + 1);
         expq.push_back(e);
         pushed++;
         m_x2[c] = m_x1[c]; m_x1[c] = xin[c];
         m_y2[c] = m_y1[c]; m_y1[c] = y;
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset) begin
         if (y_valid) begin
            yv_seen++;
            last_y[y_ch] = y_data;
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_y_valid actual=1 required=0 ch=%0d (cycle %0d)", y_ch, cyc);
            end else begin
               mon_e = expq.pop_front();
               chk("y_ch", {30'b0, y_ch}, {30'b0, mon_e.ch});
               chk("y_data", {16'b0, y_data}, {16'b0, mon_e.y});
               chk("done_with_last", {31'b0, done}, {31'b0, mon_e.dn});
               chk("y_time", cyc, mon_e.at);
            end
         end else if (done) begin
            checks++;
            failures++;
            $display("FAIL done_without_valid actual=1 required=0 (cycle %0d)", cyc);
         end
      end
   end

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_y_valid"}, {31'b0, y_valid}, 32'd0);
      chk({tag, "_y_ch"}, {30'b0, y_ch}, 32'd0);
      chk({tag, "_y_data"}, {16'b0, y_data}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, done}, 32'd0);
      chk({tag, "_coef_err"}, {31'b0, coef_err}, 32'd0);
      chk({tag, "_x_rd_ch"}, {30'b0, x_rd_ch}, 32'd0);
   endtask

   task automatic wcoef(input int c, input int s, input logic [15:0] v);
      logic [1:0] cc;
      logic [2:0] ss;
      cc = 2'(c);
      ss = 3'(s);
      @(posedge Clk); #1;
      coef_we = 1'b1; coef_ch = cc; coef_sel = ss; coef_data = v;
      @(posedge Clk); #1;
      coef_we = 1'b0;
      chk("coef_err_idle", {31'b0, coef_err}, 32'd0);
      if (s <= 5) m_coef[c][s] = v;
   endtask

   task automatic do_clear();
      @(posedge Clk); #1 clear = 1'b1;
      @(posedge Clk); #1 clear = 1'b0;
      model_hist_zero();
   endtask

   task automatic start_frame(input bit clr);
      @(posedge Clk); #1;
      start = 1'b1; clear = clr;
      @(posedge Clk); #1;
      e0 = cyc;
      start = 1'b0; clear = 1'b0;
      chk("busy_rise", {31'b0, busy}, 32'd1);
      chk("x_rd_ch_first", {30'b0, x_rd_ch}, 32'd0);
      if (clr) model_hist_zero();
      model_frame(e0);
   endtask

   task automatic finish_frame();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge Clk);
         n++;
      end
      chk("busy_fall_time", cyc, e0 + 7 * N);
      #1;
   endtask

   task automatic set_x(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
      xin[0] = a; xin[1] = b; xin[2] = c; xin[3] = d;
   endtask

   initial begin
      set_x(16'h0, 16'h0, 16'h0, 16'h0);
      for (int c = 0; c < N; c++) last_y[c] = '0;
      model_reset();
      #1 Reset = 1'b1;
      #1 chk_outputs_zero("reset");
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;

      // random warm-up frame so reset has real coefficients and history to wipe
      for (int c = 0; c < N; c++)
         for (int s = 0; s < 6; s++) wcoef(c, s, 16'($urandom));
      set_x(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      start_frame(1'b0);
      finish_frame();

      // reset three edges into a frame aborts it
      start_frame(1'b0);
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b1;
      #1 chk_outputs_zero("midreset");
      pushed -= expq.size();
      expq.delete();
      model_reset();
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      set_x(16'h1234, 16'h7FFF, 16'h8000, 16'h0F0F);
      start_frame(1'b0);
      finish_frame();
      for (int c = 0; c < N; c++) chk("zero_coef_out", {16'b0, last_y[c]}, 32'd0);

      // single-tap gain on ch0
      wcoef(0, 0, 16'h4000);
      wcoef(0, 3, 16'h7FFF);
      set_x(16'h4000, 16'h2222, 16'h3333, 16'h4444);
      start_frame(1'b0);
      finish_frame();
      chk("gain_ch0", {16'b0, last_y[0]}, 32'h07FF);

      // feedback through a1
      do_clear();
      wcoef(0, 4, 16'h4000);
      set_x(16'h4000, 16'h0, 16'h0, 16'h0);
      start_frame(1'b0);
      finish_frame();
      chk("fb_frame1", {16'b0, last_y[0]}, 32'h07FF);
      set_x(16'h0, 16'h0, 16'h0, 16'h0);
      start_frame(1'b0);
      finish_frame();
      chk("fb_frame2", {16'b0, last_y[0]}, 32'h00FF);

      // write and start while busy are both dropped
      start_frame(1'b0);
      repeat (2) @(posedge Clk);
      #1 coef_we = 1'b1; coef_ch = 2'd0; coef_sel = 3'd0; coef_data = 16'h1234; start = 1'b1;
      @(posedge Clk);
      #1 coef_we = 1'b0; start = 1'b0;
      chk("coef_err_pulse", {31'b0, coef_err}, 32'd1);
      @(posedge Clk);
      #1 chk("coef_err_single", {31'b0, coef_err}, 32'd0);
      finish_frame();
      repeat (20) @(posedge Clk);
      #1 chk("no_extra_frame_busy", {31'b0, busy}, 32'd0);
      set_x(16'h4000, 16'h0, 16'h0, 16'h0);
      start_frame(1'b0);
      finish_frame();
      wcoef(0, 6, 16'h7777);
      wcoef(0, 7, 16'h5555);

      // clear alone, then clear together with start
      do_clear();
      set_x(16'h0, 16'h0, 16'h0, 16'h0);
      start_frame(1'b0);
      finish_frame();
      chk("clear_idle_ch0", {16'b0, last_y[0]}, 32'd0);
      set_x(16'h4000, 16'h0, 16'h0, 16'h0);
      start_frame(1'b1);
      finish_frame();
      chk("clear_start_ch0", {16'b0, last_y[0]}, 32'h07FF);

      // accumulator wrap
      wcoef(0, 0, 16'h7FFF);
      wcoef(0, 1, 16'h7FFF);
      wcoef(0, 2, 16'h7FFF);
      wcoef(0, 4, 16'h0000);
      wcoef(0, 5, 16'h0000);
      do_clear();
      set_x(16'h7FFF, 16'h0, 16'h0, 16'h0);
      for (int f = 0; f < 3; f++) begin
         start_frame(1'b0);
         finish_frame();
      end
      chk("wrap_ch0", {16'b0, last_y[0]}, 32'hDFFE);

      // randomized frames
      for (int f = 0; f < 8; f++) begin
         for (int w = 0; w < 5; w++)
            wcoef($urandom_range(N - 1), $urandom_range(7), 16'($urandom));
         if ($urandom_range(4) == 0) do_clear();
         set_x(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         start_frame($urandom_range(3) == 0);
         finish_frame();
      end

      repeat (10) @(posedge Clk);
      #1;
      chk("queue_drained", expq.size(), 32'd0);
      chk("y_valid_count", yv_seen, pushed);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
